// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state types for the single-master interconnect.
package ahb_pkg;

  localparam int unsigned AHB_MAX_SLAVES = 8;
  localparam int unsigned AHB_IDX_W      = 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  // Both FSMs share one engine, so their encodings must stay aligned.
  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dflt_state_t;

  typedef enum logic [1:0] {
    W_RUN  = 2'd0,
    W_ERR1 = 2'd1,
    W_ERR2 = 2'd2
  } wdog_state_t;

endpackage

// File: rtl/ahb_default_slave_err.sv
// Two-cycle AHB ERROR sequencer: idle -> ERROR with wait -> ERROR with ready.
// Used both as the default slave and as the watchdog override engine.
module ahb_default_slave_err
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] state
);

  dflt_state_t state_q;
  dflt_state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= D_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      D_IDLE:  if (start) state_nxt = D_ERR1;
      D_ERR1:  state_nxt = D_ERR2;
      // A new erroring transfer accepted in the ready cycle chains straight on.
      D_ERR2:  state_nxt = start ? D_ERR1 : D_IDLE;
      default: state_nxt = D_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/ahb_lite_sn.sv
// Single-master AHB-Lite interconnect for up to 8 slaves: priority decode with REMAP,
// registered data-phase response mux, default ERROR slave and a per-transfer hang watchdog.
module ahb_lite_sn
  import ahb_pkg::*;
#(
  parameter int unsigned                   P_NUM        = 3,
  parameter logic [16*AHB_MAX_SLAVES-1:0] P_ADDR_START = 128'({16'h2000, 16'h1000, 16'h0000}),
  parameter logic [16*AHB_MAX_SLAVES-1:0] P_ADDR_SIZE  = 128'({16'h0100, 16'h0100, 16'h0100}),
  parameter logic [15:0]                   P_TIMEOUT    = 16'd256
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [31:0]         M_HADDR,
  input  logic [1:0]          M_HTRANS,
  input  logic                M_HWRITE,
  input  logic [2:0]          M_HSIZE,
  input  logic [2:0]          M_HBURST,
  input  logic [3:0]          M_HPROT,
  input  logic [31:0]         M_HWDATA,
  output logic [31:0]         M_HRDATA,
  output logic [1:0]          M_HRESP,
  output logic                M_HREADY,
  output logic [31:0]         HADDR,
  output logic [1:0]          HTRANS,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [2:0]          HBURST,
  output logic [3:0]          HPROT,
  output logic [31:0]         HWDATA,
  output logic                HREADY,
  output logic [P_NUM-1:0]    HSEL,
  input  logic [32*P_NUM-1:0] HRDATA_S,
  input  logic [2*P_NUM-1:0]  HRESP_S,
  input  logic [P_NUM-1:0]    HREADY_S,
  input  logic                REMAP,
  output logic                TIMEOUT,
  input  logic                TIMEOUT_CLR
);

  logic [P_NUM-1:0]     hit;
  logic                 region_found;
  logic [AHB_IDX_W-1:0] region_idx;
  logic [AHB_IDX_W-1:0] slave_idx;
  logic [P_NUM-1:0]     hsel_c;
  logic                 hseld;

  logic [P_NUM:0]       sel_d;
  logic                 act_d;

  logic [31:0]          slv_rdata;
  logic [1:0]           slv_resp;
  logic                 slv_ready;

  logic [1:0]           dflt_state_raw;
  logic [1:0]           wd_state_raw;
  dflt_state_t          dflt_state;
  wdog_state_t          wd_state;
  logic                 dflt_start;
  logic                 wd_count_en;
  logic                 wd_start;
  logic [15:0]          wd_cnt;

  assign HADDR  = M_HADDR;
  assign HTRANS = M_HTRANS;
  assign HWRITE = M_HWRITE;
  assign HSIZE  = M_HSIZE;
  assign HBURST = M_HBURST;
  assign HPROT  = M_HPROT;
  assign HWDATA = M_HWDATA;
  assign HREADY = M_HREADY;

  // Address phase: 17-bit offset from the base, so a borrow means below the region
  // and base+size past 0xFFFF cannot wrap.
  for (genvar g = 0; g < P_NUM; g++) begin : g_region
    localparam logic [16:0] BASE = {1'b0, P_ADDR_START[16*g +: 16]};
    localparam logic [16:0] SIZE = {1'b0, P_ADDR_SIZE[16*g +: 16]};
    logic [16:0] offset;
    assign offset = {1'b0, M_HADDR[31:16]} - BASE;
    assign hit[g] = (SIZE != 17'd0) && !offset[16] && (offset < SIZE);
  end

  always_comb begin
    region_found = 1'b0;
    region_idx   = '0;
    // Scanning downwards lets the lowest matching index win on overlap.
    for (int i = int'(P_NUM) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        region_found = 1'b1;
        region_idx   = AHB_IDX_W'(i);
      end
    end
    slave_idx = region_idx;
    if (REMAP && (P_NUM >= 2) && (region_idx[AHB_IDX_W-1:1] == '0))
      slave_idx[0] = ~region_idx[0];
    for (int i = 0; i < int'(P_NUM); i++)
      hsel_c[i] = region_found && (slave_idx == AHB_IDX_W'(i));
  end

  assign hseld = !region_found;
  assign HSEL  = hsel_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_d <= {1'b1, {P_NUM{1'b0}}};
      act_d <= 1'b0;
    end else if (M_HREADY) begin
      sel_d <= {hseld, hsel_c};
      act_d <= M_HTRANS[1];
    end
  end

  // Data phase: one-hot OR mux over the real slaves.
  always_comb begin
    slv_rdata = '0;
    slv_resp  = HRESP_OKAY;
    slv_ready = 1'b0;
    for (int i = 0; i < int'(P_NUM); i++) begin
      if (sel_d[i]) begin
        slv_rdata = slv_rdata | HRDATA_S[32*i +: 32];
        slv_resp  = slv_resp  | HRESP_S[2*i +: 2];
        slv_ready = slv_ready | HREADY_S[i];
      end
    end
  end

  assign dflt_start = M_HREADY && hseld && M_HTRANS[1];

  ahb_default_slave_err u_dflt (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .start (dflt_start),
    .state (dflt_state_raw)
  );

  assign dflt_state = dflt_state_t'(dflt_state_raw);

  assign wd_count_en = (P_TIMEOUT != 16'd0) && (wd_state == W_RUN) && act_d &&
                       !sel_d[P_NUM] && !slv_ready;
  assign wd_start    = wd_count_en && ((wd_cnt + 16'd1) == P_TIMEOUT);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)         wd_cnt <= '0;
    else if (wd_count_en) wd_cnt <= wd_cnt + 16'd1;
    else                  wd_cnt <= '0;
  end

  ahb_default_slave_err u_wdog (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .start (wd_start),
    .state (wd_state_raw)
  );

  assign wd_state = wdog_state_t'(wd_state_raw);

  // Setting wins over a clear in the same cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                TIMEOUT <= 1'b0;
    else if (wd_state == W_ERR1) TIMEOUT <= 1'b1;
    else if (TIMEOUT_CLR)        TIMEOUT <= 1'b0;
  end

  always_comb begin
    M_HRDATA = slv_rdata;
    M_HRESP  = slv_resp;
    M_HREADY = slv_ready;
    if (wd_state != W_RUN) begin
      M_HRDATA = '0;
      M_HRESP  = HRESP_ERROR;
      M_HREADY = (wd_state != W_ERR1);
    end else if (sel_d[P_NUM]) begin
      M_HRDATA = '0;
      M_HRESP  = (dflt_state != D_IDLE) ? HRESP_ERROR : HRESP_OKAY;
      M_HREADY = (dflt_state != D_ERR1);
    end
  end

endmodule

// File: doc/ahb_lite_sn.md
Name: ahb_lite_sn

Overview:
- Parametrised single-master AHB-Lite interconnect for up to 8 slaves.
- Contains an address decoder, a registered data-phase response mux, an internal default slave, REMAP support, and a per-transfer hang watchdog.
- Sits between one AHB-Lite master (CPU or DMA) and its slaves.
- Adds to the fixed 3-slave fabric: a configurable slave count, decode priority, and termination of stalled transfers with ERROR.

Parameters:
- P_NUM, 3: number of slaves, 1..8.
- P_ADDR_START, {16'h2000,16'h1000,16'h0000} (packed 8x16, index i at [16i+15:16i]): region base, compared with HADDR[31:16].
- P_ADDR_SIZE, {16'h0100,16'h0100,16'h0100} (packed 8x16): region size in 64 KB units; a size of 0 disables the region.
- P_TIMEOUT, 256: wait-state limit before forced ERROR; 0 disables the watchdog. Width 16 bits.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HWDATA  in  32/2/1/3/3/4/32  master request.
- M_HRDATA, M_HRESP, M_HREADY  out  32/2/1  response to the master.
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA  out  as above  broadcast to all slaves.
- HREADY  out  1  equals M_HREADY.
- HSEL  out  P_NUM  one-hot address-phase select.
- HRDATA_S  in  32*P_NUM  slave read data, packed.
- HRESP_S  in  2*P_NUM  slave responses, packed.
- HREADY_S  in  P_NUM  slave HREADYout.
- REMAP  in  1  swaps regions 0 and 1.
- TIMEOUT  out  1  sticky watchdog flag.
- TIMEOUT_CLR  in  1  clears TIMEOUT.

Behaviour:
- Decode (combinational):
  - Region i hits when START_i <= HADDR[31:16] < START_i+SIZE_i, using 17-bit arithmetic so no wrap.
  - On overlap, the lowest index wins.
  - No hit selects the default slave (HSELd). HSEL is independent of HTRANS.
- REMAP=1 with P_NUM>=2: an address in region 0 asserts HSEL[1], and region 1 asserts HSEL[0]. REMAP is sampled combinationally.
- Data-phase select:
  - sel_d is a (P_NUM+1)-bit one-hot register, with the default slave at the top bit.
  - It loads {HSELd,HSEL} when M_HREADY=1 and holds otherwise.
  - A flag act_d loads (HTRANS[1]) under the same condition.
- Response mux:
  - M_HRDATA, M_HRESP and M_HREADY come from the slave indicated by sel_d, or from the default slave.
  - When the watchdog is forcing, the mux is overridden (see Watchdog).
- Reset values:
  - sel_d = default slave, act_d = 0.
  - M_HREADY = 1, M_HRESP = OKAY, M_HRDATA = 0.
  - TIMEOUT = 0, watchdog counter = 0.
- Default slave FSM, states D_IDLE, D_ERR1, D_ERR2:
  - D_IDLE: output HREADY=1, OKAY, HRDATA=0. A NONSEQ/SEQ accepted with HSELd=1 and M_HREADY=1 moves to D_ERR1. IDLE/BUSY transfers get a zero-wait OKAY.
  - D_ERR1: output HREADY=0, ERROR. Always moves to D_ERR2.
  - D_ERR2: output HREADY=1, ERROR. Moves to D_ERR1 if another unmapped NONSEQ/SEQ is accepted this cycle, otherwise to D_IDLE.
- Watchdog FSM, states W_RUN, W_ERR1, W_ERR2:
  - W_RUN counting:
    - The counter increments while act_d=1, a real slave is selected, and the selected HREADY_S=0.
    - It clears whenever the selected HREADY_S=1.
    - When the counter reaches P_TIMEOUT, move to W_ERR1.
  - W_ERR1: force M_HREADY=0, HRESP=ERROR. Set TIMEOUT. Next state W_ERR2.
  - W_ERR2: force M_HREADY=1, HRESP=ERROR, HRDATA=0. Next state W_RUN, counter cleared.
  - Slave inputs are ignored in W_ERR1 and W_ERR2.
  - The slave then sees HREADY=1 and must abandon the transfer; this is a system-level requirement.
- TIMEOUT:
  - Set has priority over TIMEOUT_CLR in the same cycle.
  - Otherwise TIMEOUT_CLR=1 clears it on the next edge.
- P_TIMEOUT=0: the watchdog FSM stays in W_RUN and the counter stays at 0.
- Reset asserted mid-transfer: all state returns asynchronously to its reset values. The next cycle is a zero-wait OKAY from the default slave.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP codes (OKAY/ERROR/RETRY/SPLIT).
  - The P_NUM max constant (8).
  - State encodings for both FSMs.
- One sub-module, ahb_default_slave_err: the two-cycle ERROR FSM.
  - The same FSM is reused by the watchdog override path, with its start input driven by the timeout condition.

Test Plan:
- Reset, then IDLE transfers -> M_HREADY=1, HRESP=OKAY, TIMEOUT=0, HSEL=000 when HADDR is outside all regions.
- Single reads to 0x0000_0010, 0x1000_0020 and 0x2000_0030, with slave i returning 0xA0+i after one wait state -> HSEL one-hot 001/010/100 in the address phase, and M_HRDATA = 0xA0/0xA1/0xA2 in the data phase.
- NONSEQ to 0x3000_0000 -> cycle 1 HREADY=0/ERROR, cycle 2 HREADY=1/ERROR. Repeat back-to-back and check D_ERR2 -> D_ERR1.
- REMAP=1, read 0x0000_0000 -> HSEL=010. Read 0x1000_0000 -> HSEL=001.
- P_TIMEOUT=4, slave 1 holding HREADY_S=0 -> after 4 wait cycles, two-cycle ERROR and TIMEOUT=1. TIMEOUT_CLR pulse -> TIMEOUT=0. Simultaneous set and clear -> TIMEOUT stays 1.
- HRESETn asserted during a slave wait and during D_ERR1 -> outputs return to reset values immediately. First post-reset transfer decodes correctly.
